// File: rtl/halt_dump_unit_pkg.sv
// Shared definitions for the halt-triggered data-memory dump engine.
// The halt word and memory geometry are also used by the CPU fetch logic and the data RAM.
package halt_dump_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        RD,
        CAP,
        SEND,
        DONE
    } dump_state_e;

    localparam logic [31:0] HALT_WORD         = 32'hFFFF_FFFF;
    localparam int          DUMP_DATA_W       = 32;
    localparam int          DUMP_DEPTH        = 512;
    localparam int          DUMP_ADDR_W       = 9;
    localparam int          DUMP_DRAIN_CYCLES = 10;

endpackage

// File: rtl/halt_dump_unit_dump_out_reg.sv
// Single-entry valid/ready holding register: load sets valid, the entry is
// held stable until a handshake clears valid.
module dump_out_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            addr_d  = load_addr;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign addr  = addr_q;

endmodule

// File: rtl/halt_dump_unit.sv
// Waits for the CPU halt word, lets in-flight stores drain, then streams data
// RAM words 0..DEPTH-1 out over a valid/ready port, one word every 3 cycles.
module halt_dump_unit
    import halt_dump_unit_pkg::*;
#(
    parameter int          DATA_W       = DUMP_DATA_W,
    parameter int          DEPTH        = DUMP_DEPTH,
    parameter int          ADDR_W       = DUMP_ADDR_W,
    parameter int          DRAIN_CYCLES = DUMP_DRAIN_CYCLES,
    parameter logic [31:0] HALT_WORD    = halt_dump_unit_pkg::HALT_WORD
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [31:0]       instr_f,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              halted,
    output logic              done
);

    localparam int                CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

    dump_state_e       state_q, state_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              halted_q, halted_d;
    logic              handshake;

    assign handshake = dump_valid && dump_ready;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        addr_d      = addr_q;
        halted_d    = halted_q;
        case (state_q)
            IDLE: begin
                if (instr_f == HALT_WORD) begin
                    halted_d    = 1'b1;
                    drain_cnt_d = '0;
                    addr_d      = '0;
                    state_d     = (DRAIN_CYCLES == 0) ? RD : DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + CNT_W'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    addr_d  = '0;
                    state_d = RD;
                end
            end
            RD:   state_d = CAP;
            CAP:  state_d = SEND;
            SEND: begin
                if (handshake) begin
                    // Terminal compare on DEPTH-1 so the address never wraps.
                    if (addr_q == ADDR_LAST) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            addr_q      <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            addr_q      <= addr_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_rd_en   = (state_q == RD);
    assign mem_rd_addr = (state_q == RD) ? addr_q : '0;
    assign halted      = halted_q;
    assign done        = (state_q == DONE);

    // RAM data arrives during CAP, one cycle after the RD strobe.
    dump_out_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk       (CLOCK),
        .srst      (RESET),
        .load      (state_q == CAP),
        .load_data (mem_rd_data),
        .load_addr (addr_q),
        .ready     (dump_ready),
        .valid     (dump_valid),
        .data      (dump_data),
        .addr      (dump_addr)
    );

endmodule

// File: tb/tb_halt_dump_unit.sv
// Directed bench for halt_dump_unit: full dumps, backpressure, spurious halts,
// mid-dump reset, repeat halt after done, and a zero-drain small instance.
module tb_halt_dump_unit;

    localparam int DW     = 32;
    localparam int DEPTH  = 512;
    localparam int AW     = 9;
    localparam int DEPTH1 = 4;
    localparam int AW1    = 2;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic [31:0]   instr_f;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;
    logic          halted;
    logic          done;

    logic [31:0]    instr1;
    logic           mem_rd_en1;
    logic [AW1-1:0] mem_rd_addr1;
    logic [DW-1:0]  mem_rd_data1;
    logic           dump_valid1;
    logic           dump_ready1;
    logic [DW-1:0]  dump_data1;
    logic [AW1-1:0] dump_addr1;
    logic           halted1;
    logic           done1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } word_t;

    word_t         sb[$];
    logic [DW-1:0] ram0 [DEPTH];
    logic [DW-1:0] ram1 [DEPTH1];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            rd_count = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        cyc <= cyc + 1;
        if (mem_rd_en)  mem_rd_data  <= ram0[mem_rd_addr];
        if (mem_rd_en1) mem_rd_data1 <= ram1[mem_rd_addr1];
    end

    halt_dump_unit dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .instr_f     (instr_f),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_addr   (dump_addr),
        .halted      (halted),
        .done        (done)
    );

    halt_dump_unit #(
        .DEPTH        (DEPTH1),
        .ADDR_W       (AW1),
        .DRAIN_CYCLES (0)
    ) dut1 (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .instr_f     (instr1),
        .mem_rd_en   (mem_rd_en1),
        .mem_rd_addr (mem_rd_addr1),
        .mem_rd_data (mem_rd_data1),
        .dump_valid  (dump_valid1),
        .dump_ready  (dump_ready1),
        .dump_data   (dump_data1),
        .dump_addr   (dump_addr1),
        .halted      (halted1),
        .done        (done1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe at the falling edge (handshakes about to complete), then advance past the rising edge.
    task automatic tick();
        word_t w;
        @(negedge CLOCK);
        if (mem_rd_en) rd_count++;
        if (dump_valid && dump_ready && !RESET) begin
            last_addr = dump_addr;
            last_data = dump_data;
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
                w = sb.pop_front();
                chk("sb_addr", 64'(dump_addr), 64'(w.addr));
                chk("sb_data", 64'(dump_data), 64'(w.data));
                $display("word addr=%0d data=%0d", dump_addr, dump_data);
            end
        end
        if (dump_valid1 && dump_ready1 && !RESET)
            chk("d1_data", 64'(dump_data1), 64'(32'(dump_addr1) * 5 + 7));
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_all();
        for (int i = 0; i < DEPTH; i++)
            sb.push_back('{addr: AW'(i), data: DW'(i * 3 + 1)});
    endtask

    task automatic do_halt(output int hc);
        instr_f = 32'hFFFF_FFFF;
        tick();
        hc = cyc;
        instr_f = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"},   64'(mem_rd_en),   64'd0);
        chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
        chk({tag, "_valid"},   64'(dump_valid),  64'd0);
        chk({tag, "_data"},    64'(dump_data),   64'd0);
        chk({tag, "_addr"},    64'(dump_addr),   64'd0);
        chk({tag, "_halted"},  64'(halted),      64'd0);
        chk({tag, "_done"},    64'(done),        64'd0);
    endtask

    initial begin
        int hc;
        int rc;
        RESET       = 1'b1;
        instr_f     = 32'h0;
        instr1      = 32'h0;
        dump_ready  = 1'b1;
        dump_ready1 = 1'b1;
        for (int i = 0; i < DEPTH; i++)  ram0[i] = DW'(i * 3 + 1);
        for (int i = 0; i < DEPTH1; i++) ram1[i] = DW'(i * 5 + 7);
        tick();
        tick();
        chk_all_zero("reset");
        RESET = 1'b0;
        tick();

        // Near-miss and zero fetch words must not trigger.
        instr_f = 32'hFFFF_FFFE;
        tick();
        instr_f = 32'h0000_0000;
        repeat (4) tick();
        chk("spurious_halted", 64'(halted), 64'd0);
        chk("spurious_rd", 64'(rd_count), 64'd0);

        // Full dump with ready held high.
        push_all();
        do_halt(hc);
        chk("halted_rise", 64'(halted), 64'd1);
        for (int i = 0; i < 40 && !dump_valid; i++) tick();
        chk("first_valid_lat", 64'(cyc - hc), 64'd12);
        chk("first_addr", 64'(dump_addr), 64'd0);
        chk("first_data", 64'(dump_data), 64'd1);
        for (int i = 0; i < 3000 && !done; i++) tick();
        chk("done_cycle", 64'(cyc - hc), 64'd1546);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("last_addr", 64'(last_addr), 64'd511);
        chk("last_data", 64'(last_data), 64'd1534);
        chk("rd_pulses", 64'(rd_count), 64'd512);

        // Halt word after done: no restart.
        rc = rd_count;
        instr_f = 32'hFFFF_FFFF;
        tick();
        instr_f = 32'h0;
        repeat (6) tick();
        chk("rehalt_no_rd", 64'(rd_count), 64'(rc));
        chk("rehalt_done", 64'(done), 64'd1);
        chk("rehalt_halted", 64'(halted), 64'd1);
        chk("rehalt_valid", 64'(dump_valid), 64'd0);

        // Backpressure on word 5, then reset while word 100 is waiting in SEND.
        RESET = 1'b1;
        tick();
        chk_all_zero("reset2");
        RESET = 1'b0;
        tick();
        push_all();
        do_halt(hc);
        for (int i = 0; i < 200 && !(dump_valid && dump_addr == AW'(5)); i++) tick();
        chk("bp_found", 64'(dump_addr), 64'd5);
        dump_ready = 1'b0;
        rc = rd_count;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("stall_valid", 64'(dump_valid), 64'd1);
            chk("stall_addr", 64'(dump_addr), 64'd5);
            chk("stall_data", 64'(dump_data), 64'd16);
        end
        chk("stall_no_rd", 64'(rd_count), 64'(rc));
        dump_ready = 1'b1;
        for (int i = 0; i < 1000 && !(dump_valid && dump_addr == AW'(100)); i++) tick();
        chk("send100_found", 64'(dump_addr), 64'd100);
        dump_ready = 1'b0;
        RESET = 1'b1;
        tick();
        chk_all_zero("midreset");
        sb.delete();
        RESET = 1'b0;
        dump_ready = 1'b1;
        tick();
        push_all();
        do_halt(hc);
        for (int i = 0; i < 3000 && !done; i++) tick();
        chk("restart_done_cycle", 64'(cyc - hc), 64'd1546);
        chk("restart_sb_drained", 64'(sb.size()), 64'd0);

        // Zero-drain instance: read strobe immediately after the halt edge.
        instr1 = 32'hFFFF_FFFF;
        tick();
        hc = cyc;
        instr1 = 32'h0;
        chk("d1_rd_en", 64'(mem_rd_en1), 64'd1);
        chk("d1_rd_addr", 64'(mem_rd_addr1), 64'd0);
        chk("d1_halted", 64'(halted1), 64'd1);
        repeat (11) tick();
        chk("d1_not_done", 64'(done1), 64'd0);
        tick();
        chk("d1_done", 64'(done1), 64'd1);
        chk("d1_done_cycle", 64'(cyc - hc), 64'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
